// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector with run-time pattern reload, selectable overlap,
// sample stall and a saturating match counter; y rises the cycle after the completing bit.
module seq_detect_moore #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic [N-1:0]     pat
);

  localparam int               FW      = $clog2(N + 1);
  localparam logic [FW-1:0]    FULL    = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     hist, hist_nxt, h_shift, pat_nxt;
  logic [FW-1:0]    fill, fill_nxt, fill_sat, f_inc;
  logic             found, found_nxt, match;
  logic [CNT_W-1:0] count_nxt;

  // Out-of-range fill is folded back to N so a corrupted counter recovers in one edge.
  assign fill_sat = (fill > FULL) ? FULL : fill;
  assign f_inc    = (fill_sat == FULL) ? FULL : fill_sat + 1'b1;
  assign h_shift  = {hist[N-2:0], x};
  assign match    = (f_inc == FULL) && (h_shift == pat);

  always_comb begin
    pat_nxt   = pat;
    hist_nxt  = hist;
    fill_nxt  = fill;
    found_nxt = found;
    if (load) begin
      pat_nxt   = pat_in;
      hist_nxt  = '0;
      fill_nxt  = '0;
      found_nxt = 1'b0;
    end else if (en) begin
      if (match) begin
        found_nxt = 1'b1;
        hist_nxt  = overlap ? h_shift : '0;
        fill_nxt  = overlap ? FULL : '0;
      end else begin
        found_nxt = 1'b0;
        hist_nxt  = h_shift;
        fill_nxt  = f_inc;
      end
    end
  end

  // clr beats a coincident increment; the counter sticks at its maximum.
  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (!load && en && match && (count != CNT_MAX))
      count_nxt = count + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat   <= PATTERN;
      hist  <= '0;
      fill  <= '0;
      found <= 1'b0;
      count <= '0;
    end else begin
      pat   <= pat_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      found <= found_nxt;
      count <= count_nxt;
    end
  end

  assign y = found;

endmodule

// File: tb/tb_seq_detect_moore.sv
// Bench for seq_detect_moore: directed scenarios plus randomized traffic against a queue-based model.
module tb_seq_detect_moore;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       x, en, overlap, load, clr;
  logic [3:0] pat_in;
  logic       y, y2;
  logic [7:0] count;
  logic [1:0] count2;
  logic [3:0] pat, pat2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         mq[$];
  logic [3:0] m_pat;
  logic       m_y;
  int         m_c8, m_c2;

  seq_detect_moore #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr(clr), .y(y), .count(count), .pat(pat));

  seq_detect_moore #(.N(4), .PATTERN(4'b1101), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr(clr), .y(y2), .count(count2), .pat(pat2));

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_pat = 4'b1101;
    m_y   = 1'b0;
    m_c8  = 0;
    m_c2  = 0;
  endtask

  function automatic bit model_hit();
    if (mq.size() != N) return 1'b0;
    for (int i = 0; i < N; i++)
      if (mq[i] != m_pat[N-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  // Called right after a posedge with the inputs that were sampled there.
  task automatic model_step();
    bit hit;
    if (!reset) begin
      model_reset();
      return;
    end
    if (clr) begin
      m_c8 = 0;
      m_c2 = 0;
    end
    if (load) begin
      m_pat = pat_in;
      mq.delete();
      m_y = 1'b0;
    end else if (en) begin
      mq.push_back(x);
      if (mq.size() > N) void'(mq.pop_front());
      hit = model_hit();
      m_y = hit;
      if (hit) begin
        if (!clr) begin
          if (m_c8 < 255) m_c8++;
          if (m_c2 < 3) m_c2++;
        end
        if (!overlap) mq.delete();
      end
    end
  endtask

  task automatic step(input logic xi, input logic ei, input logic li, input logic ci,
                      input logic [3:0] pi);
    x = xi; en = ei; load = li; clr = ci; pat_in = pi;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    x = 0; en = 0; load = 0; clr = 0; pat_in = 0; overlap = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] bits;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(i[0], 1'b1, 1'b0, 1'b0, 4'b0000);
      checks++;
      if (y !== 1'b0 || count !== 8'd0 || pat !== 4'b1101 || count2 !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold y=%b count=%0d pat=%b count2=%0d required y=0 count=0 pat=1101",
                 y, count, pat, count2);
      end
    end
    reset = 1'b1;
    bits = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0, 1'b0, 4'b0000);
      checks++;
      if (y !== 1'b0 || y !== m_y) begin
        errors++;
        $display("FAIL reset_first_bits bit%0d y=%b required 0", 2 - i, y);
      end
    end
  endtask

  task automatic run_stream(input string name, input logic ov);
    logic [6:0] s;
    s = 7'b1101101;
    do_reset();
    overlap = ov;
    for (int i = 0; i < 7; i++) begin
      logic ey;
      step(s[6-i], 1'b1, 1'b0, 1'b0, 4'b0000);
      ey = (i == 3) || (ov && i == 6);
      checks++;
      if (y !== ey || y !== m_y || count !== m_c8[7:0]) begin
        errors++;
        $display("FAIL %s bit%0d y=%b count=%0d required y=%b count=%0d",
                 name, i + 1, y, count, ey, m_c8);
      end
    end
    checks++;
    if (count !== (ov ? 8'd2 : 8'd1)) begin
      errors++;
      $display("FAIL %s_count count=%0d required %0d", name, count, ov ? 2 : 1);
    end
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1);
  endtask

  task automatic test_nonoverlap();
    run_stream("nonoverlap", 1'b0);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111);
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (y !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL ones_overlap y=%b count=%0d required y=1 count=1", y, count);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL ones_hold_en0 y=%b required 1", y);
    end
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111);
    overlap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic ey;
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      ey = (i == 3) || (i == 7);
      checks++;
      if (y !== ey || y !== m_y) begin
        errors++;
        $display("FAIL ones_nonoverlap bit%0d y=%b required %b", i + 1, y, ey);
      end
    end
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL ones_nonoverlap_count count=%0d required 2", count);
    end
  endtask

  task automatic test_stall_load();
    logic [3:0] np;
    do_reset();
    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(i[0], 1'b0, 1'b0, 1'b0, 4'b0000);
      checks++;
      if (y !== 1'b0 || count !== 8'd0) begin
        errors++;
        $display("FAIL stall cyc%0d y=%b count=%0d required y=0 count=0", i, y, count);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (y !== 1'b1 || count !== 8'd1) begin
      errors++;
      $display("FAIL stall_resume y=%b count=%0d required y=1 count=1", y, count);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
    checks++;
    if (y !== 1'b0 || pat !== 4'b0110 || count !== 8'd1) begin
      errors++;
      $display("FAIL load y=%b pat=%b count=%0d required y=0 pat=0110 count=1", y, pat, count);
    end
    np = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      logic ey;
      step(np[i], 1'b1, 1'b0, 1'b0, 4'b0000);
      ey = (i == 0);
      checks++;
      if (y !== ey) begin
        errors++;
        $display("FAIL load_match bit%0d y=%b required %b", 4 - i, y, ey);
      end
    end
  endtask

  task automatic test_sat_clr();
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111);
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (count2 !== 2'd3 || count !== 8'd5) begin
      errors++;
      $display("FAIL saturate count2=%0d count=%0d required count2=3 count=5", count2, count);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
    checks++;
    if (y !== 1'b1 || count !== 8'd0 || count2 !== 2'd0) begin
      errors++;
      $display("FAIL clr_match y=%b count=%0d count2=%0d required y=1 count=0", y, count, count2);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (count !== 8'd1 || count2 !== 2'd1) begin
      errors++;
      $display("FAIL after_clr count=%0d count2=%0d required 1", count, count2);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] s;
    do_reset();
    s = 4'b1101;
    for (int i = 3; i >= 0; i--) step(s[i], 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL async_pre y=%b required 1", y);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (y !== 1'b0 || count !== 8'd0 || pat !== 4'b1101) begin
      errors++;
      $display("FAIL async_reset y=%b count=%0d pat=%b required y=0 count=0 pat=1101",
               y, count, pat);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      overlap = ($urandom_range(0, 9) < 7);
      step($urandom_range(0, 1), $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 3,
           ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b1101);
      checks++;
      if (y !== m_y || y2 !== m_y || count !== m_c8[7:0] || count2 !== m_c2[1:0] ||
          pat !== m_pat || pat2 !== m_pat) begin
        errors++;
        $display("FAIL random cyc%0d y=%b count=%0d count2=%0d pat=%b required y=%b count=%0d count2=%0d pat=%b",
                 i, y, count, count2, pat, m_y, m_c8, m_c2, m_pat);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    x = 0; en = 0; overlap = 1; load = 0; clr = 0; pat_in = 0;
    model_reset();
    #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_stall_load();
    test_sat_clr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
